// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neuron-array control blocks.
//   nn_state_t       : 3-bit loader sequencer state encoding
//   CONFIG_NUM_WIDTH : width of the layer/neuron index fields on the config bus
//   cnt_width()      : bits needed for a counter that must reach max_count
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_LOAD_W = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_NEXT   = 3'd4
    } nn_state_t;

    localparam int CONFIG_NUM_WIDTH = 32;

    // Counter width able to hold the value max_count itself (never below 1 bit)
    function automatic int cnt_width(input int max_count);
        int w;
        if (max_count < 1) begin
            w = 1;
        end else begin
            w = $clog2(max_count + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/nn_burst_counter.sv
// Reusable burst counter with parallel load, increment and terminal-count flag.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   load/load_value : synchronous load (has priority over inc)
//   inc             : count up by one
//   count           : current count
//   at_last         : count equals TERMINAL-1 (last element of a burst)
module nn_burst_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_last
);

    localparam logic [WIDTH-1:0] LAST_VALUE = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count_r;

    // Count register: load wins over increment, otherwise hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (inc) begin
            count_r <= count_r + WIDTH'(1);
        end
    end

    assign count   = count_r;
    assign at_last = (count_r == LAST_VALUE);

endmodule

// File: rtl/neuron_param_loader.sv
// Streams weights then bias for each neuron of one layer from a shared word
// stream onto the neuron broadcast configuration bus.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start, abort             : begin a load (IDLE only) / return to IDLE
//   s_data, s_valid, s_ready : parameter word stream (s_ready decoded from state)
//   neuron_clr               : one-cycle pulse clearing neuron write pointers
//   config_layer_num         : constant LAYER_NO
//   config_neuron_num        : neuron currently being loaded
//   weightValid/weightValue  : registered weight word
//   biasValid/biasValue      : registered bias word
//   busy, done               : sequencer active / last bias issued
//   checksum                 : modular sum of accepted words when
//                              NEURON_PARAM_LOADER_CHECKSUM_EN is defined, else 0
module neuron_param_loader
    import nn_ctrl_pkg::*;
#(
    parameter int LAYER_NO    = 0,
    parameter int NUM_NEURONS = 32,
    parameter int NUM_WEIGHTS = 1024,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        neuron_clr,
    output logic [CONFIG_NUM_WIDTH-1:0] config_layer_num,
    output logic [CONFIG_NUM_WIDTH-1:0] config_neuron_num,
    output logic                        weightValid,
    output logic [DATA_WIDTH-1:0]       weightValue,
    output logic                        biasValid,
    output logic [DATA_WIDTH-1:0]       biasValue,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_WIDTH-1:0]       checksum
);

    localparam int W_CNT_WIDTH = cnt_width(NUM_WEIGHTS);
    localparam int N_CNT_WIDTH = cnt_width(NUM_NEURONS);

    nn_state_t state_r, fsm_next_s, next_state_s;

    logic                   hs_s, w_accept_s, b_accept_s, done_set_s;
    logic                   w_load_s, w_last_s, n_load_s, n_inc_s, n_last_s;
    // Only the terminal flag of the weight counter steers the sequencer
    logic [W_CNT_WIDTH-1:0] w_cnt_unused_s;
    logic [N_CNT_WIDTH-1:0] n_cnt_s;

    logic                  neuron_clr_r, weight_valid_r, bias_valid_r, busy_r, done_r;
    logic [DATA_WIDTH-1:0] weight_value_r, bias_value_r;

    assign s_ready = (state_r == ST_LOAD_W) || (state_r == ST_LOAD_B);
    assign hs_s    = s_valid && s_ready;

    // An aborted cycle never forwards a word, even if a handshake is on the bus
    assign w_accept_s = hs_s && (state_r == ST_LOAD_W) && !abort;
    assign b_accept_s = hs_s && (state_r == ST_LOAD_B) && !abort;
    assign done_set_s = (state_r == ST_NEXT) && n_last_s && !abort;

    // Weight count restarts for every neuron; it only runs inside LOAD_W
    assign w_load_s = abort || (state_r != ST_LOAD_W);
    // Neuron index is zeroed while idle so a restart always begins at neuron 0
    assign n_load_s = abort || (state_r == ST_IDLE) || (state_r == ST_CLR);
    assign n_inc_s  = (state_r == ST_NEXT) && !n_last_s && !abort;

    nn_burst_counter #(.WIDTH(W_CNT_WIDTH), .TERMINAL(NUM_WEIGHTS)) u_w_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load_s),
        .load_value ({W_CNT_WIDTH{1'b0}}),
        .inc        (w_accept_s),
        .count      (w_cnt_unused_s),
        .at_last    (w_last_s)
    );

    nn_burst_counter #(.WIDTH(N_CNT_WIDTH), .TERMINAL(NUM_NEURONS)) u_n_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (n_load_s),
        .load_value ({N_CNT_WIDTH{1'b0}}),
        .inc        (n_inc_s),
        .count      (n_cnt_s),
        .at_last    (n_last_s)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; abort overrides every transition
    always_comb begin
        fsm_next_s   = state_r;
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) fsm_next_s = ST_CLR;
                else       fsm_next_s = ST_IDLE;
            end
            ST_CLR: fsm_next_s = ST_LOAD_W;
            ST_LOAD_W: begin
                if (hs_s && w_last_s) fsm_next_s = ST_LOAD_B;
                else                  fsm_next_s = ST_LOAD_W;
            end
            ST_LOAD_B: begin
                if (hs_s) fsm_next_s = ST_NEXT;
                else      fsm_next_s = ST_LOAD_B;
            end
            ST_NEXT: begin
                if (n_last_s) fsm_next_s = ST_IDLE;
                else          fsm_next_s = ST_LOAD_W;
            end
            default: fsm_next_s = ST_IDLE;
        endcase
        if (abort) begin
            next_state_s = ST_IDLE;
        end else begin
            next_state_s = fsm_next_s;
        end
    end

    // Output registers: pulses decoded from the next state, data words held between valids
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neuron_clr_r   <= 1'b0;
            weight_valid_r <= 1'b0;
            weight_value_r <= {DATA_WIDTH{1'b0}};
            bias_valid_r   <= 1'b0;
            bias_value_r   <= {DATA_WIDTH{1'b0}};
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            neuron_clr_r   <= (next_state_s == ST_CLR);
            busy_r         <= (next_state_s != ST_IDLE);
            done_r         <= done_set_s;
            weight_valid_r <= w_accept_s;
            bias_valid_r   <= b_accept_s;
            if (w_accept_s) weight_value_r <= s_data;
            if (b_accept_s) bias_value_r   <= s_data;
        end
    end

    assign neuron_clr        = neuron_clr_r;
    assign weightValid       = weight_valid_r;
    assign weightValue       = weight_value_r;
    assign biasValid         = bias_valid_r;
    assign biasValue         = bias_value_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign config_layer_num  = CONFIG_NUM_WIDTH'(LAYER_NO);
    assign config_neuron_num = CONFIG_NUM_WIDTH'(n_cnt_s);

`ifdef NEURON_PARAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_r;

    // Modular sum of accepted words; restarts in the clear cycle, held after done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_r <= {DATA_WIDTH{1'b0}};
        end else if (state_r == ST_CLR) begin
            checksum_r <= {DATA_WIDTH{1'b0}};
        end else if (w_accept_s || b_accept_s) begin
            checksum_r <= checksum_r + s_data;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_neuron_param_loader.sv
module tb_neuron_param_loader;

    localparam int NN    = 2;
    localparam int NW    = 4;
    localparam int LAYER = 3;
    localparam int PER   = NW + 1;
`ifdef NEURON_PARAM_LOADER_CHECKSUM_EN
    localparam bit CK_ON = 1'b1;
`else
    localparam bit CK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    // main instance (2 neurons x 4 weights, layer 3)
    logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0, s_ready;
    logic [15:0] s_data = 16'd0;
    logic        neuron_clr, weightValid, biasValid, busy, done;
    logic [31:0] config_layer_num, config_neuron_num;
    logic [15:0] weightValue, biasValue, checksum;

    // degenerate instance (1 neuron x 1 weight, layer 0)
    logic        d1_start = 1'b0, d1_abort = 1'b0, d1_valid = 1'b0, d1_ready;
    logic [15:0] d1_data = 16'd0;
    logic        d1_clr, d1_wv, d1_bv, d1_busy, d1_done;
    logic [31:0] d1_layer, d1_neuron;
    logic [15:0] d1_wval, d1_bval, d1_sum;

    int checks = 0;
    int errors = 0;

    // reference model: position in the word list plus phase flags
    bit          m_active, m_clr, m_gap, last_hs;
    int          m_pos, m_neuron;
    bit          e_wv, e_bv, e_clr, e_done;
    logic [15:0] e_wval, e_bval, e_sum;

    neuron_param_loader #(.LAYER_NO(LAYER), .NUM_NEURONS(NN), .NUM_WEIGHTS(NW), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .neuron_clr(neuron_clr), .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num), .weightValid(weightValid), .weightValue(weightValue),
        .biasValid(biasValid), .biasValue(biasValue), .busy(busy), .done(done), .checksum(checksum)
    );

    neuron_param_loader #(.LAYER_NO(0), .NUM_NEURONS(1), .NUM_WEIGHTS(1), .DATA_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .start(d1_start), .abort(d1_abort), .s_data(d1_data), .s_valid(d1_valid),
        .s_ready(d1_ready), .neuron_clr(d1_clr), .config_layer_num(d1_layer),
        .config_neuron_num(d1_neuron), .weightValid(d1_wv), .weightValue(d1_wval),
        .biasValid(d1_bv), .biasValue(d1_bval), .busy(d1_busy), .done(d1_done), .checksum(d1_sum)
    );

    // free-running clock, period 10
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_clr = 1'b0; m_gap = 1'b0; m_pos = 0; m_neuron = 0;
        e_wv = 1'b0; e_bv = 1'b0; e_clr = 1'b0; e_done = 1'b0;
        e_wval = 16'd0; e_bval = 16'd0; e_sum = 16'd0; last_hs = 1'b0;
    endtask

    // one cycle: check outputs at the falling edge, drive inputs, advance the model
    task automatic tick(input bit v, input logic [15:0] d, input bit st, input bit ab);
        bit rdy, hs;
        @(negedge clk);
        rdy = m_active && !m_clr && !m_gap;
        check("weightValid", 32'(weightValid), 32'(e_wv));
        check("biasValid", 32'(biasValid), 32'(e_bv));
        check("weightValue", 32'(weightValue), 32'(e_wval));
        check("biasValue", 32'(biasValue), 32'(e_bval));
        check("neuron_clr", 32'(neuron_clr), 32'(e_clr));
        check("done", 32'(done), 32'(e_done));
        check("busy", 32'(busy), 32'(m_active));
        check("s_ready", 32'(s_ready), 32'(rdy));
        check("config_layer_num", config_layer_num, 32'(LAYER));
        check("checksum", 32'(checksum), CK_ON ? 32'(e_sum) : 32'd0);
        if (m_active) check("config_neuron_num", config_neuron_num, 32'(m_neuron));
        s_valid = v; s_data = d; start = st; abort = ab;
        hs = v && rdy && !ab;
        last_hs = hs;
        e_wv = 1'b0; e_bv = 1'b0; e_clr = 1'b0; e_done = 1'b0;
        if (m_active && m_clr) e_sum = 16'd0;
        else if (hs) e_sum = e_sum + d;
        if (ab) begin
            m_active = 1'b0; m_clr = 1'b0; m_gap = 1'b0; m_neuron = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1; m_clr = 1'b1; m_pos = 0; m_neuron = 0; e_clr = 1'b1;
            end
        end else if (m_clr) begin
            m_clr = 1'b0;
        end else if (m_gap) begin
            m_gap = 1'b0;
            if (m_neuron == NN - 1) begin
                m_active = 1'b0; e_done = 1'b1;
            end else begin
                m_neuron++;
            end
        end else if (hs) begin
            if (m_pos % PER == NW) begin
                e_bv = 1'b1; e_bval = d; m_gap = 1'b1;
            end else begin
                e_wv = 1'b1; e_wval = d;
            end
            m_pos++;
        end
    endtask

    // offer n words; mode 0 = valid held, 1 = valid toggled, 2 = random valid and data
    task automatic feed(input int n, input int mode, input logic [15:0] base);
        int got = 0;
        int cyc = 0;
        bit v;
        logic [15:0] d;
        d = (mode == 2) ? 16'($urandom) : base;
        while (got < n && cyc < 300) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            tick(v, d, 1'b0, 1'b0);
            if (last_hs) begin
                got++;
                d = (mode == 2) ? 16'($urandom) : base + 16'(got);
            end
            cyc++;
        end
        check("feed_budget", 32'(got), 32'(n));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #2;
        check("rst_weightValid", 32'(weightValid), 32'd0);
        check("rst_biasValid", 32'(biasValid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_neuron_clr", 32'(neuron_clr), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_layer", config_layer_num, 32'd3);
        check("rst_neuron", config_neuron_num, 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_d1_layer", d1_layer, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // degenerate size: one weight, one neuron
        @(negedge clk); d1_start = 1'b1;
        @(negedge clk);
        check("deg_clr", 32'(d1_clr), 32'd1);
        check("deg_ready_in_clr", 32'(d1_ready), 32'd0);
        d1_start = 1'b0; d1_valid = 1'b1; d1_data = 16'h7FFF;
        @(negedge clk);
        check("deg_ready", 32'(d1_ready), 32'd1);
        check("deg_wv_early", 32'(d1_wv), 32'd0);
        @(negedge clk);
        check("deg_wv", 32'(d1_wv), 32'd1);
        check("deg_wval", 32'(d1_wval), 32'h7FFF);
        check("deg_bv_early", 32'(d1_bv), 32'd0);
        d1_data = 16'h8000;
        @(negedge clk);
        check("deg_bv", 32'(d1_bv), 32'd1);
        check("deg_bval", 32'(d1_bval), 32'h8000);
        check("deg_wv_after", 32'(d1_wv), 32'd0);
        d1_valid = 1'b0;
        @(negedge clk);
        check("deg_done", 32'(d1_done), 32'd1);
        check("deg_busy", 32'(d1_busy), 32'd0);
        check("deg_checksum", 32'(d1_sum), CK_ON ? 32'h0000FFFF : 32'd0);
        @(negedge clk);
        check("deg_done_pulse", 32'(d1_done), 32'd0);
        check("deg_checksum_hold", 32'(d1_sum), CK_ON ? 32'h0000FFFF : 32'd0);

        // basic load: words 1..10 back to back
        tick(1'b0, 16'd0, 1'b1, 1'b0);
        feed(10, 0, 16'd1);
        idle(3);
        check("basic_checksum", 32'(checksum), CK_ON ? 32'd55 : 32'd0);

        // backpressure: valid toggled
        tick(1'b0, 16'd0, 1'b1, 1'b0);
        feed(10, 1, 16'h0100);
        idle(3);

        // start while busy is ignored
        tick(1'b0, 16'd0, 1'b1, 1'b0);
        feed(2, 0, 16'h0200);
        tick(1'b0, 16'd0, 1'b1, 1'b0);
        feed(8, 0, 16'h0202);
        idle(3);

        // random valid gaps and random data
        for (int r = 0; r < 3; r++) begin
            tick(1'b0, 16'd0, 1'b1, 1'b0);
            feed(10, 2, 16'd0);
            idle(3);
        end

        // abort after third weight of neuron 1, with a word offered in the abort cycle
        tick(1'b0, 16'd0, 1'b1, 1'b0);
        feed(8, 0, 16'h0300);
        tick(1'b1, 16'hDEAD, 1'b0, 1'b1);
        idle(3);
        tick(1'b0, 16'd0, 1'b1, 1'b0);
        feed(10, 0, 16'h0400);
        idle(3);

        // start and abort together in IDLE: abort wins
        tick(1'b0, 16'd0, 1'b1, 1'b1);
        idle(2);

        // asynchronous reset during LOAD_B
        tick(1'b0, 16'd0, 1'b1, 1'b0);
        feed(4, 0, 16'h0500);
        @(posedge clk); #2;
        check("pre_rst_weightValid", 32'(weightValid), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_weightValid", 32'(weightValid), 32'd0);
        check("arst_weightValue", 32'(weightValue), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_s_ready", 32'(s_ready), 32'd0);
        check("arst_layer", config_layer_num, 32'd3);
        check("arst_checksum", 32'(checksum), 32'd0);
        s_valid = 1'b0; start = 1'b0; abort = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 16'd0, 1'b1, 1'b0);
        feed(10, 0, 16'h0600);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
